// File: rtl/mul_acc_iter_pkg.sv
// +------------------------------------------------------------------------+
// | mul_acc_iter_pkg                                                       |
// | State, accumulate-mode and handshake codes for the iterative MAC unit. |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

package mul_acc_iter_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE   = 2'd0,
    MAC_BUSY   = 2'd1,
    MAC_FINISH = 2'd2,
    MAC_DONE   = 2'd3
  } mac_state_e;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_ADD  = 2'b01;
  localparam logic [1:0] ACC_SUB  = 2'b10;
  localparam logic [1:0] ACC_RSVD = 2'b11;

  localparam logic MAC_START          = 1'b1;
  localparam logic MAC_STOP           = 1'b0;
  localparam logic MAC_RESULT_READY   = 1'b1;
  localparam logic MAC_RESULT_NOT_RDY = 1'b0;

  // The reserved encoding behaves as a plain multiply.
  function automatic logic [1:0] norm_acc_mode(input logic [1:0] mode);
    return (mode == ACC_RSVD) ? ACC_NONE : mode;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_acc_iter_if.sv
// +------------------------------------------------------------------------+
// | mul_acc_iter_if                                                        |
// | start/ready handshake and operand/result bus between EX and the MAC.   |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

interface mul_acc_iter_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic                 annul_i;
  logic                 signed_i;
  logic [1:0]           acc_mode_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic [2*WIDTH-1:0]   hilo_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;

  modport master (
    output start_i, annul_i, signed_i, acc_mode_i, opdata1_i, opdata2_i, hilo_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, annul_i, signed_i, acc_mode_i, opdata1_i, opdata2_i, hilo_i,
    output result_o, ready_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/mac_pp_gen.sv
// +------------------------------------------------------------------------+
// | mac_pp_gen                                                             |
// | WIDTH x BPC partial product, zero-extended to 2*WIDTH.                 |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module mac_pp_gen #(
  parameter int WIDTH = 32,
  parameter int BPC   = 8
) (
  input  wire logic [WIDTH-1:0]   mcand_i,
  input  wire logic [BPC-1:0]     chunk_i,
  output logic      [2*WIDTH-1:0] pp_o
);

  assign pp_o = (2*WIDTH)'(mcand_i) * (2*WIDTH)'(chunk_i);

endmodule

`default_nettype wire

// File: rtl/mul_acc_iter.sv
// +------------------------------------------------------------------------+
// | mul_acc_iter                                                           |
// | Iterative signed/unsigned multiply and multiply-accumulate, BPC bits   |
// | per cycle. Optional MULACC_EARLY_OUT_EN ends BUSY once the remaining   |
// | multiplier is zero.                                                    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module mul_acc_iter
  import mul_acc_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mul_acc_iter_if.slave   bus
);

  localparam int N      = WIDTH / BPC;
  localparam int STEP_W = $clog2(N + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  if (WIDTH % BPC != 0) begin : g_cfg_check
    $error("mul_acc_iter: WIDTH must be a multiple of BPC");
  end

  mac_state_e           state_q,   state_d;
  logic [WIDTH-1:0]     mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic                 neg_q,     neg_d;
  logic [1:0]           acc_q,     acc_d;
  logic [2*WIDTH-1:0]   hilo_q,    hilo_d;
  logic [2*WIDTH-1:0]   partial_q, partial_d;
  logic [STEP_W-1:0]    step_q,    step_d;
  logic [2*WIDTH-1:0]   result_q,  result_d;
  logic [2*WIDTH-1:0]   res_out_q, res_out_d;
  logic                 ready_q,   ready_d;
  logic                 busy_q,    busy_d;

  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mag1;
  logic [WIDTH-1:0]     mag2;
  logic [WIDTH-1:0]     mplier_next;
  logic                 last_step;

  mac_pp_gen #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_pp_gen (
    .mcand_i (mcand_q),
    .chunk_i (mplier_q[BPC-1:0]),
    .pp_o    (pp)
  );

  // W-bit magnitudes: negating the most negative value yields 2^(W-1) unsigned.
  assign mag1 = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2 = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  assign mplier_next = mplier_q >> BPC;
  assign prod        = neg_q ? -partial_q : partial_q;

`ifdef MULACC_EARLY_OUT_EN
  assign last_step = (step_q == LAST_STEP) || (mplier_next == '0);
`else
  assign last_step = (step_q == LAST_STEP);
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    hilo_d    = hilo_q;
    partial_d = partial_q;
    step_d    = step_q;
    result_d  = result_q;

    if (bus.annul_i) begin
      state_d = MAC_IDLE;
    end else begin
      case (state_q)
        MAC_IDLE: begin
          if (bus.start_i == MAC_START) begin
            mcand_d   = mag1;
            mplier_d  = mag2;
            neg_d     = bus.signed_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            acc_d     = norm_acc_mode(bus.acc_mode_i);
            hilo_d    = bus.hilo_i;
            partial_d = '0;
            step_d    = '0;
            state_d   = MAC_BUSY;
          end
        end
        MAC_BUSY: begin
          partial_d = partial_q + (pp << (int'(step_q) * BPC));
          mplier_d  = mplier_next;
          step_d    = step_q + STEP_W'(1);
          if (last_step) state_d = MAC_FINISH;
        end
        MAC_FINISH: begin
          case (acc_q)
            ACC_ADD: result_d = hilo_q + prod;
            ACC_SUB: result_d = hilo_q - prod;
            default: result_d = prod;
          endcase
          state_d = MAC_DONE;
        end
        MAC_DONE: begin
          if (bus.start_i == MAC_STOP) state_d = MAC_IDLE;
        end
        default: state_d = MAC_IDLE;
      endcase
    end

    // Result is presented one edge after DONE is reached, and only while DONE holds.
    ready_d   = (state_q == MAC_DONE && state_d == MAC_DONE) ? MAC_RESULT_READY : MAC_RESULT_NOT_RDY;
    res_out_d = ready_d ? result_q : '0;
    busy_d    = (state_d == MAC_BUSY) || (state_d == MAC_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MAC_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      acc_q     <= ACC_NONE;
      hilo_q    <= '0;
      partial_q <= '0;
      step_q    <= '0;
      result_q  <= '0;
      res_out_q <= '0;
      ready_q   <= MAC_RESULT_NOT_RDY;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      hilo_q    <= hilo_d;
      partial_q <= partial_d;
      step_q    <= step_d;
      result_q  <= result_d;
      res_out_q <= res_out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.result_o = res_out_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

`default_nettype wire
